// File: rtl/count_disp_pkg.sv
// Shared constants and types for the count history display: the digit count,
// the digit-index type and the active-high hex-to-segment code table.
package count_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Bit order {g,f,e,d,c,b,a}, entry n is the glyph for hex digit n
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder; output is always active-high,
// the parent applies any polarity inversion.
module hex_to_seg7
    import count_disp_pkg::*;
(
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    always_comb begin
        seg_out = SEG_TABLE[hex_in];
    end

endmodule

// File: rtl/count_history_display.sv
// Keeps the last four distinct count_in values and scans them onto a
// four-digit multiplexed 7-segment display, newest value on the rightmost digit.
module count_history_display
    import count_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       new_val
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    // XOR masks: all-ones flips to active-low, all-zeros leaves active-high
    localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF   = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic        DP_OFF   = SEG_ACTIVE_LOW;

    logic [3:0]  last_q, last_d;
    logic [3:0]  hist_q [NUM_DIGITS];
    logic [3:0]  hist_d [NUM_DIGITS];
    logic        new_val_q, new_val_d;
    logic [15:0] presc_q, presc_d;
    digit_idx_t  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  raw_seg;
    logic        scan_tick;

    hex_to_seg7 u_dec (
        .hex_in  (hist_q[idx_q]),
        .seg_out (raw_seg)
    );

    always_comb begin
        last_d    = last_q;
        hist_d    = hist_q;
        new_val_d = 1'b0;
        if (count_in != last_q) begin
            last_d = count_in;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = count_in;
            new_val_d = 1'b1;
        end

        scan_tick = (presc_q == DIV_LAST);
        presc_d   = scan_tick ? 16'd0 : presc_q + 16'd1;
        idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;

        // Display outputs come from the current index/history, so they lag one edge
        seg_d = raw_seg ^ SEG_OFF;
        an_d  = (4'b0001 << idx_q) ^ AN_OFF;
        dp_d  = (idx_q == 2'd0) ^ DP_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= 4'd0;
            hist_q    <= '{default: 4'd0};
            new_val_q <= 1'b0;
            presc_q   <= 16'd0;
            idx_q     <= 2'd0;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            an_q      <= AN_OFF;
        end else begin
            last_q    <= last_d;
            hist_q    <= hist_d;
            new_val_q <= new_val_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign new_val = new_val_q;

endmodule

// File: doc/count_history_display.md
COUNT_HISTORY_DISPLAY -- requirements
Module: count_history_display

Interface
REQ-001 SCAN_DIV, default 1000, clk cycles per displayed digit; legal range 1..65535.
REQ-002 SEG_ACTIVE_LOW, default 1; 1 = seg, dp and an are active-low, 0 = active-high.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 count_in  input  4  count value from the upstream counter_clk_div, same clk domain.
REQ-006 seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}.
REQ-007 dp  output  1  decimal point drive.
REQ-008 an  output  4  digit enables, one-hot when active; an[0] = rightmost digit.
REQ-009 new_val  output  1  one-cycle pulse, high in the cycle after a count_in change is captured.

Function
REQ-010 Held register last_q (4 b) SHALL compare count_in to last_q every cycle.
REQ-011 On count_in != last_q: last_q <= count_in; hist[3] <= hist[2], hist[2] <= hist[1], hist[1] <= hist[0], hist[0] <= count_in; new_val <= 1.
REQ-012 On count_in == last_q: hist and last_q hold; new_val <= 0.
REQ-013 Back-to-back changes on consecutive cycles SHALL each shift once; new_val stays high across them.
REQ-014 Prescaler (16 b) counts 0..SCAN_DIV-1 and wraps to 0; scan_tick = prescaler == SCAN_DIV-1.
REQ-015 On scan_tick, digit index (2 b) advances 0->1->2->3->0.
REQ-016 SCAN_DIV = 1 SHALL advance the index every cycle.
REQ-017 seg, dp, an SHALL be registered: they reflect index and hist as sampled at the previous edge (1-cycle latency).
REQ-018 seg = hex decode of hist[index], active-high codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; inverted when SEG_ACTIVE_LOW=1.
REQ-019 an asserts only bit [index]; dp asserted only when index = 0 (marks newest value).
REQ-020 Simultaneous history shift and scan_tick SHALL both take effect on the same edge; no event is dropped.
REQ-021 Outputs SHALL never show more than one enabled digit in any cycle.

Reset
REQ-022 While reset is high at a rising edge: last_q, hist[0..3], prescaler, index <= 0; new_val <= 0.
REQ-023 Reset values of outputs: an, seg and dp all inactive (SEG_ACTIVE_LOW=1: an=4'hF, seg=7'h7F, dp=1).
REQ-024 The first non-reset edge SHALL resume normal operation; the outputs become active with a digit-0 display one cycle later.
REQ-025 A reset asserted mid-scan or mid-change SHALL discard that in-flight change; no new_val pulse follows.
REQ-026 count_in SHALL be treated as 0 at reset, so a nonzero count_in at the first post-reset edge counts as a change.

Structure
REQ-027 Package count_disp_pkg SHALL hold the 16-entry segment code table, the NUM_DIGITS = 4 constant and the digit-index type.
REQ-028 Sub-module hex_to_seg7 (4-bit in, 7-bit active-high out, combinational) SHALL implement REQ-018; polarity inversion stays in the parent.
REQ-029 No other clocks, clock enables from logic, or latches.

Verification
REQ-030 Reset 2 cycles with SEG_ACTIVE_LOW=1 -> an=F, seg=7F, dp=1, new_val=0 during reset and in the first cycle after it.
REQ-031 count_in 0->1->2->3->4, one step per 10 cycles -> 4 new_val pulses; hist = {1,2,3,4} in the order hist[3]..hist[0].
REQ-032 Continue REQ-031 with SCAN_DIV=4 -> an cycles E,D,B,7 with 4 cycles per digit; seg = 66,4F,5B,06 inverted; dp low only while an=E.
REQ-033 count_in changes on 3 consecutive cycles (5,6,7) -> new_val high 3 cycles; hist[0]=7, hist[1]=6, hist[2]=5.
REQ-034 count_in change coincident with scan_tick at index 3 -> the next cycle shows the index-0 digit with the new value on seg.
REQ-035 Assert reset for 1 cycle mid-scan at index 2 with hist nonzero -> the next edge clears hist and index to 0; outputs inactive for one cycle; no new_val pulse.
